neuron_argmax_collector: RTL and testbench
==========================================

// Module: neuron_argmax_collector
// PURPOSE
//  Sits directly downstream of the 5-stage 28:1 adder tree (+Beta). Consumes the tree's 26-bit sum.
//  - Tracks which cycles carry a valid sum with a valid-tag delay line, since the tree has no valid.
//  - Applies ReLU, rescales and saturates each sum, and streams out the per-neuron activations.
//  - After N_NEURONS sums, reports the argmax class index and its score.
// PARAMETERS
//  DATA_W     26  width of adder-tree sum (signed two's complement)
//  TREE_LAT   15  cycles from tree operand presentation to valid sum_in (5 stages x (FF + 2-cycle adder))
//  N_NEURONS  10  sums per frame
//  IDX_W      4   neuron/class index width; must satisfy 2**IDX_W >= N_NEURONS
//  FRAC_SHIFT 8   arithmetic right shift applied before saturation
//  OUT_W      16  unsigned activation width
// PORTS
//  clk          in   1       clock
//  GlobalReset  in   1       reset, synchronous, active-high
//  tree_issue   in   1       high in the cycle Result_28/Beta are presented to the adder tree
//  sum_in       in   DATA_W  adder-tree Result_1
//  act_valid    out  1       act_data/act_idx valid (1-cycle pulse)
//  act_data     out  OUT_W   ReLU+scaled+saturated activation
//  act_idx      out  IDX_W   neuron index within frame, 0..N_NEURONS-1
//  class_valid  out  1       argmax result valid (1-cycle pulse)
//  class_idx    out  IDX_W   index of maximum activation
//  class_score  out  OUT_W   maximum activation value
//  busy         out  1       frame in progress (state ACC) or tags in flight
// BEHAVIOUR
//  - One clock domain; clk and GlobalReset as named above.
//  - Reset, synchronous and active-high: all outputs 0; delay line, counters, max registers cleared; state IDLE.
//    Reset mid-frame discards partial frame and in-flight tags; no class_valid for it.
//  - Tag line: TREE_LAT-deep shift register of tree_issue. Capture occurs when tag[TREE_LAT-1]=1; sum_in sampled that cycle.
//    Back-to-back issue every cycle supported. Captures are never dropped and there is no back-pressure.
//  - Activation: if sum_in[DATA_W-1]=1 then a=0; else s=sum_in>>>FRAC_SHIFT and a = (s > 2**OUT_W-1) ? 2**OUT_W-1 : s.
//  - Activation outputs: act_valid/act_data/act_idx registered 1 cycle after capture.
//  - FSM states IDLE, ACC, REPORT:
//    IDLE->ACC on capture: idx=0, max=a, max_idx=0.
//    ACC, each capture: idx+1. If a > max (strict), max=a and max_idx=idx. Ties keep the lower index.
//    ACC->REPORT on the capture with idx==N_NEURONS-1.
//    REPORT lasts 1 cycle: class_valid=1 with class_idx/class_score. Same cycle as the last act_valid.
//    REPORT->IDLE, or REPORT->ACC if a capture occurs in REPORT (that capture is idx 0 of the next frame).
//  - class_idx/class_score hold their value until the next REPORT; class_valid and act_valid are pulses.
//  - Latency: tree_issue of the last neuron -> class_valid = TREE_LAT+1 cycles.
// CONFIGURATION
//  - Macro NAC_SAT_STICKY_EN defined:
//    Adds output sat_seen (1 bit), set when any activation in the current frame saturated.
//    sat_seen is cleared at the idx-0 capture of each frame and at reset.
//    Its value is valid alongside class_valid.
//  - Macro undefined: port sat_seen and its logic are absent; all other behaviour identical.
// TESTING
//  1 Reset: GlobalReset high 3 cycles with tree_issue=1 -> no act_valid/class_valid for TREE_LAT+2 cycles after release; outputs 0.
//  2 Single frame, 10 issues back-to-back, sums 0x0001234 for idx 3 and 0x0000100 for the rest ->
//    act_data 0x0012 at idx 3, 0x0001 elsewhere; class_valid at cycle TREE_LAT+1 after last issue; class_idx=3; class_score=0x0012.
//  3 Negative/saturation: sum 0x3FFFF00 -> act_data 0. Sum 0x1FFFFFF -> act_data 0xFFFF; sat_seen=1 with NAC_SAT_STICKY_EN.
//  4 Ties: all 10 sums 0x0000500 -> class_idx=0, class_score=0x0005.
//  5 Gapped issues plus frame chaining: random 0-3 cycle gaps, 2 frames with first issue of frame 2 landing in REPORT cycle ->
//    two class_valid pulses, act_idx restarts at 0, no lost sum.
//  6 Reset mid-frame after 6 captures, then a full frame -> exactly one class_valid, for the new frame only.

Source files
------------

// File: rtl/neuron_argmax_collector.sv
// Post-adder-tree collector: valid-tag delay line, ReLU/rescale/saturate, per-frame argmax.
// Optional macro NAC_SAT_STICKY_EN adds the sat_seen per-frame saturation flag.
module neuron_argmax_collector #(
  parameter int DATA_W     = 26,
  parameter int TREE_LAT   = 15,
  parameter int N_NEURONS  = 10,
  parameter int IDX_W      = 4,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = 16
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              tree_issue,
  input  logic [DATA_W-1:0] sum_in,
  output logic              act_valid,
  output logic [OUT_W-1:0]  act_data,
  output logic [IDX_W-1:0]  act_idx,
  output logic              class_valid,
  output logic [IDX_W-1:0]  class_idx,
  output logic [OUT_W-1:0]  class_score,
  output logic              busy
`ifdef NAC_SAT_STICKY_EN
  ,
  output logic              sat_seen
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, REPORT} state_t;

  state_t              state, state_nxt;
  logic [TREE_LAT-1:0] tag;
  logic                capture;
  logic [DATA_W-1:0]   shifted;
  logic                sat;
  logic [OUT_W-1:0]    act;
  logic [IDX_W-1:0]    cnt, cur_idx;
  logic                first, last;
  logic [OUT_W-1:0]    max_val, max_nxt;
  logic [IDX_W-1:0]    max_idx, max_idx_nxt;

  // The tree carries no valid, so the issue strobe is aged alongside it.
  assign capture = tag[TREE_LAT-1];

  // Only consulted for non-negative sums, so a logical shift equals the arithmetic one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    shifted = sum_in >> FRAC_SHIFT;
    sat     = 1'b0;
    act     = '0;
    if (!sum_in[DATA_W-1]) begin
      sat = |shifted[DATA_W-1:OUT_W];
      act = sat ? '1 : shifted[OUT_W-1:0];
    end
  end

  // A capture outside ACC (IDLE or REPORT) always opens a new frame at index 0.
  always_comb begin
    first       = (state != ACC);
    cur_idx     = first ? '0 : cnt;
    last        = (cur_idx == IDX_W'(N_NEURONS - 1));
    max_nxt     = max_val;
    max_idx_nxt = max_idx;
    state_nxt   = state;
    if (capture && (first || act > max_val)) begin
      max_nxt     = act;
      max_idx_nxt = cur_idx;
    end
    if (capture)
      state_nxt = last ? REPORT : ACC;
    else if (state == REPORT)
      state_nxt = IDLE;
  end

  // The tag line is cleared on reset so in-flight sums from an aborted frame are discarded.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      tag         <= '0;
      state       <= IDLE;
      cnt         <= '0;
      max_val     <= '0;
      max_idx     <= '0;
      act_valid   <= 1'b0;
      act_data    <= '0;
      act_idx     <= '0;
      class_idx   <= '0;
      class_score <= '0;
`ifdef NAC_SAT_STICKY_EN
      sat_seen    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tag       <= {tag[TREE_LAT-2:0], tree_issue};
      state     <= state_nxt;
      act_valid <= capture;
      if (capture) begin
        act_data <= act;
        act_idx  <= cur_idx;
        cnt      <= cur_idx + 1'b1;
        max_val  <= max_nxt;
        max_idx  <= max_idx_nxt;
`ifdef NAC_SAT_STICKY_EN
        sat_seen <= first ? sat : (sat_seen | sat);
`endif
        if (last) begin
          class_idx   <= max_idx_nxt;
          class_score <= max_nxt;
        end
      end
    end
  end

  assign class_valid = (state == REPORT);
  assign busy        = (state == ACC) || (|tag);

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// Scoreboard bench for neuron_argmax_collector: a frame-level reference model predicts
// every activation and class report, a negedge monitor pops and compares them.
module tb_neuron_argmax_collector;
  localparam int DATA_W   = 26;
  localparam int TREE_LAT = 15;
  localparam int N        = 10;
  localparam int IDX_W    = 4;
  localparam int OUT_W    = 16;

  logic              clk = 1'b0;
  logic              GlobalReset;
  logic              tree_issue;
  logic [DATA_W-1:0] sum_in;
  logic              act_valid;
  logic [OUT_W-1:0]  act_data;
  logic [IDX_W-1:0]  act_idx;
  logic              class_valid;
  logic [IDX_W-1:0]  class_idx;
  logic [OUT_W-1:0]  class_score;
  logic              busy;
`ifdef NAC_SAT_STICKY_EN
  logic              sat_seen;
`endif

  always #5 clk = ~clk;

  neuron_argmax_collector dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .tree_issue  (tree_issue),
    .sum_in      (sum_in),
    .act_valid   (act_valid),
    .act_data    (act_data),
    .act_idx     (act_idx),
    .class_valid (class_valid),
    .class_idx   (class_idx),
    .class_score (class_score),
    .busy        (busy)
`ifdef NAC_SAT_STICKY_EN
    ,
    .sat_seen    (sat_seen)
`endif
  );

  typedef struct { int cyc; int data; int idx; } act_exp_t;
  typedef struct { int cyc; int idx; int score; bit sat; } cls_exp_t;

  act_exp_t          act_q[$];
  cls_exp_t          cls_q[$];
  int                frame[$];
  bit                frame_sat;
  logic [DATA_W-1:0] sched[int];
  int                cyc    = 0;
  int                checks = 0;
  int                errors = 0;
  act_exp_t          ea;
  cls_exp_t          ec;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // ReLU, divide by 256, clamp to 16 bits.
  function automatic int ref_act(input logic [DATA_W-1:0] s, output bit saturated);
    longint v;
    v = longint'($signed(s));
    saturated = 1'b0;
    if (v < 0) return 0;
    v = v / 256;
    if (v > 65535) begin
      saturated = 1'b1;
      return 65535;
    end
    return int'(v);
  endfunction

  task automatic model_issue(input logic [DATA_W-1:0] s);
    int a;
    int best;
    bit st;
    a = ref_act(s, st);
    act_q.push_back('{cyc + TREE_LAT + 1, a, frame.size()});
    frame.push_back(a);
    frame_sat = frame_sat | st;
    if (frame.size() == N) begin
      best = 0;
      for (int i = 1; i < N; i++)
        if (frame[i] > frame[best]) best = i;
      cls_q.push_back('{cyc + TREE_LAT + 1, best, frame[best], frame_sat});
      frame.delete();
      frame_sat = 1'b0;
    end
  endtask

  // Reset in cycle r silences outputs from cycle r+1 on; partial frame is lost.
  task automatic model_reset();
    act_exp_t ka[$];
    cls_exp_t kc[$];
    foreach (act_q[i]) if (act_q[i].cyc <= cyc) ka.push_back(act_q[i]);
    foreach (cls_q[i]) if (cls_q[i].cyc <= cyc) kc.push_back(cls_q[i]);
    act_q = ka;
    cls_q = kc;
    frame.delete();
    frame_sat = 1'b0;
  endtask

  // One clock cycle of stimulus; sum_in carries the sum belonging to the issue TREE_LAT cycles ago.
  task automatic step(input bit iss, input logic [DATA_W-1:0] s, input bit rst);
    GlobalReset = rst;
    tree_issue  = iss;
    if (rst) model_reset();
    else if (iss) begin
      sched[cyc + TREE_LAT] = s;
      model_issue(s);
    end
    sum_in = sched.exists(cyc) ? sched[cyc] : DATA_W'($urandom);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic [DATA_W-1:0] s, input int gap);
    step(1'b1, s, 1'b0);
    idle(gap);
  endtask

  function automatic logic [DATA_W-1:0] rand_sum();
    case ($urandom_range(0, 7))
      0:       return DATA_W'(-int'($urandom_range(1, 1 << 20)));
      1:       return DATA_W'($urandom_range(1 << 24, (1 << 25) - 1));
      default: return DATA_W'($urandom_range(0, 1 << 22));
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_act_valid"}, act_valid, 0);
    check({tag, "_class_valid"}, class_valid, 0);
    check({tag, "_class_idx"}, class_idx, 0);
    check({tag, "_class_score"}, class_score, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: every output pulse must match the oldest expectation at its exact cycle.
  always @(negedge clk) begin
    while (act_q.size() > 0 && act_q[0].cyc < cyc) begin
      ea = act_q.pop_front();
      check("act_missing", 0, 1);
    end
    while (cls_q.size() > 0 && cls_q[0].cyc < cyc) begin
      ec = cls_q.pop_front();
      check("class_missing", 0, 1);
    end
    if (act_valid === 1'b1) begin
      if (act_q.size() == 0) check("act_unexpected", 1, 0);
      else begin
        ea = act_q.pop_front();
        check("act_cycle", cyc, ea.cyc);
        check("act_data", act_data, ea.data);
        check("act_idx", act_idx, ea.idx);
      end
    end
    if (class_valid === 1'b1) begin
      if (cls_q.size() == 0) check("class_unexpected", 1, 0);
      else begin
        ec = cls_q.pop_front();
        check("class_cycle", cyc, ec.cyc);
        check("class_idx", class_idx, ec.idx);
        check("class_score", class_score, ec.score);
`ifdef NAC_SAT_STICKY_EN
        check("sat_seen", sat_seen, ec.sat);
`endif
      end
    end
  end

  initial begin
    frame_sat = 1'b0;
    // Reset held with issue asserted: nothing may come out afterwards.
    repeat (3) step(1'b1, DATA_W'(26'h100), 1'b1);
    check_reset_state("reset");
    idle(TREE_LAT + 3);

    // Single back-to-back frame, peak at index 3.
    for (int i = 0; i < N; i++) send((i == 3) ? DATA_W'(26'h0001234) : DATA_W'(26'h0000100), 0);
    idle(TREE_LAT + 3);

    // Negative and saturating sums, then a clean frame so sat_seen must clear.
    for (int i = 0; i < N; i++)
      send((i == 0) ? DATA_W'(26'h3FFFF00) : (i == 1) ? DATA_W'(26'h1FFFFFF)
                    : DATA_W'($urandom_range(0, 24'hFFFFFF)), 0);
    for (int i = 0; i < N; i++) send(DATA_W'($urandom_range(0, 24'hFFFFFF)), 0);
    idle(TREE_LAT + 3);

    // All equal: lowest index wins.
    for (int i = 0; i < N; i++) send(DATA_W'(26'h0000500), 0);
    idle(TREE_LAT + 3);

    // Gapped issues, second frame's first capture lands in the REPORT cycle.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2 * N; i++) send(rand_sum(), (i == N - 1) ? 0 : $urandom_range(0, 3));
      idle(TREE_LAT + 3);
    end

    // Reset after 6 captures, then a full frame.
    for (int i = 0; i < 6; i++) send(rand_sum(), 0);
    idle(TREE_LAT + 2);
    step(1'b0, '0, 1'b1);
    check_reset_state("midreset");
    for (int i = 0; i < N; i++) send(rand_sum(), $urandom_range(0, 2));
    idle(TREE_LAT + 3);

    // Reset with tags still in flight, then random chained frames.
    for (int i = 0; i < 4; i++) send(rand_sum(), 0);
    idle(5);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3 * N; i++) send(rand_sum(), $urandom_range(0, 1));
    idle(TREE_LAT + 5);

    check("act_queue_drained", act_q.size(), 0);
    check("class_queue_drained", cls_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
